// File: rtl/io_owner_pkg.sv
// Shared definitions for the pad-ownership controller: FSM state codes,
// register offsets inside the Wishbone window, and pad register reset values.
package io_owner_pkg;

  typedef logic [1:0] own_state_t;

  localparam own_state_t OWN_PRJ      = 2'd0;
  localparam own_state_t GUARD_TO_WB  = 2'd1;
  localparam own_state_t OWN_WB       = 2'd2;
  localparam own_state_t GUARD_TO_PRJ = 2'd3;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_GOUT_LO = 8'h08;
  localparam logic [7:0] OFF_GOUT_HI = 8'h0C;
  localparam logic [7:0] OFF_GOEB_LO = 8'h10;
  localparam logic [7:0] OFF_GOEB_HI = 8'h14;

  // GPIO pads come out of reset driving 0 with their drivers disabled
  localparam logic GOUT_RST_BIT = 1'b0;
  localparam logic GOEB_RST_BIT = 1'b1;

endpackage

// File: rtl/io_owner_wb_regs.sv
// Wishbone classic register file: CTRL, STATUS and the GPIO drive/enable
// registers. Single-cycle registered ack, one ack per qualified strobe.
module io_owner_wb_regs
  import io_owner_pkg::*;
#(
  parameter int          NPADS = 38,
  parameter logic [31:0] BASE  = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             owner,
  input  logic             busy,
  output logic             req_owner,
  output logic [NPADS-1:0] gout,
  output logic [NPADS-1:0] goeb
);

  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic             ctrl_reg;
  logic [NPADS-1:0] gout_reg, gout_next;
  logic [NPADS-1:0] goeb_reg, goeb_next;
  logic [7:0]       offset;
  logic             hit;
  logic             wr;
  logic [31:0]      rdata;
  logic [31:0]      gout_hi, goeb_hi;

  assign offset = wbs_adr_i[7:0];
  // Masking with ack_reg keeps a still-held strobe from re-qualifying in its ack cycle
  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE[31:8]) & ~ack_reg;
  assign wr  = hit & wbs_we_i;

  genvar gi;
  generate
    for (gi = 0; gi < NPADS; gi++) begin : g_pad_bit
      localparam int         LANE    = (gi % 32) / 8;
      localparam logic [7:0] OUT_OFF = (gi < 32) ? OFF_GOUT_LO : OFF_GOUT_HI;
      localparam logic [7:0] OEB_OFF = (gi < 32) ? OFF_GOEB_LO : OFF_GOEB_HI;
      logic lane_wr;
      assign lane_wr = wr & wbs_sel_i[LANE];
      assign gout_next[gi] = (lane_wr && offset == OUT_OFF) ? wbs_dat_i[gi % 32] : gout_reg[gi];
      assign goeb_next[gi] = (lane_wr && offset == OEB_OFF) ? wbs_dat_i[gi % 32] : goeb_reg[gi];
    end
  endgenerate

  always_comb begin
    gout_hi = '0;
    goeb_hi = '0;
    gout_hi[NPADS-33:0] = gout_reg[NPADS-1:32];
    goeb_hi[NPADS-33:0] = goeb_reg[NPADS-1:32];
    rdata = '0;
    case (offset)
      OFF_CTRL:    rdata[0]   = ctrl_reg;
      OFF_STATUS:  rdata[1:0] = {busy, owner};
      OFF_GOUT_LO: rdata      = gout_reg[31:0];
      OFF_GOUT_HI: rdata      = gout_hi;
      OFF_GOEB_LO: rdata      = goeb_reg[31:0];
      OFF_GOEB_HI: rdata      = goeb_hi;
      default:     rdata      = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_reg  <= 1'b0;
      dat_reg  <= '0;
      ctrl_reg <= 1'b0;
      gout_reg <= {NPADS{GOUT_RST_BIT}};
      goeb_reg <= {NPADS{GOEB_RST_BIT}};
    end else begin
      ack_reg  <= hit;
      dat_reg  <= (hit & ~wbs_we_i) ? rdata : '0;
      gout_reg <= gout_next;
      goeb_reg <= goeb_next;
      if (wr && offset == OFF_CTRL && wbs_sel_i[0]) begin
        ctrl_reg <= wbs_dat_i[0];
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign req_owner = ctrl_reg;
  assign gout      = gout_reg;
  assign goeb      = goeb_reg;

endmodule

// File: rtl/io_owner_ctrl.sv
// Hands the user IO pads between the project and Wishbone GPIO, tri-stating
// them for GUARD cycles on every ownership change.
module io_owner_ctrl
  import io_owner_pkg::*;
#(
  parameter int          NPADS = 38,
  parameter int          GUARD = 4,
  parameter logic [31:0] BASE  = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPADS-1:0] prj_io_out,
  input  logic [NPADS-1:0] prj_io_oeb,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic             owner_o,
  output logic             busy_o
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

  own_state_t       state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             req_owner;
  logic [NPADS-1:0] gout, goeb;
  logic             owner, busy;

  assign owner = (state_reg == OWN_WB);
  assign busy  = (state_reg == GUARD_TO_WB) || (state_reg == GUARD_TO_PRJ);

  io_owner_wb_regs #(
    .NPADS(NPADS),
    .BASE (BASE)
  ) u_regs (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .owner    (owner),
    .busy     (busy),
    .req_owner(req_owner),
    .gout     (gout),
    .goeb     (goeb)
  );

  // Requests are only sampled in the own states, so a flip during a guard waits for it to end
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      OWN_PRJ: if (req_owner) begin
        state_next = GUARD_TO_WB;
        cnt_next   = GUARD_LOAD;
      end
      GUARD_TO_WB: if (cnt_reg == 4'd0) state_next = OWN_WB;
                   else cnt_next = cnt_reg - 4'd1;
      OWN_WB: if (!req_owner) begin
        state_next = GUARD_TO_PRJ;
        cnt_next   = GUARD_LOAD;
      end
      default: if (cnt_reg == 4'd0) state_next = OWN_PRJ;
               else cnt_next = cnt_reg - 4'd1;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= OWN_PRJ;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    case (state_reg)
      OWN_PRJ: begin
        io_out = prj_io_out;
        io_oeb = prj_io_oeb;
      end
      OWN_WB: begin
        io_out = gout;
        io_oeb = goeb;
      end
      default: begin
        io_out = '0;
        io_oeb = '1;
      end
    endcase
  end

  assign owner_o = owner;
  assign busy_o  = busy;

endmodule

// File: tb/tb_io_owner_ctrl.sv
// Self-checking bench for io_owner_ctrl: a bus/ownership model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_io_owner_ctrl;

  localparam int          NPADS = 38;
  localparam int          GUARD = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] HI_MASK = 32'((64'd1 << (NPADS - 32)) - 64'd1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]       sel = '0;
  logic [31:0]      dat_i = '0, adr = '0;
  logic             ack;
  logic [31:0]      dat_o;
  logic [NPADS-1:0] prj_out = '0, prj_oeb = '1;
  logic [NPADS-1:0] io_out, io_oeb;
  logic             owner, busy;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0, prj_cnt = 0, ack_cnt = 0, consec_cnt = 0;
  logic ack_prev = 1'b0;

  always #5 clk = ~clk;

  io_owner_ctrl #(.NPADS(NPADS), .GUARD(GUARD), .BASE(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .prj_io_out(prj_out),
    .prj_io_oeb(prj_oeb),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .owner_o   (owner),
    .busy_o    (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_req;
  logic [63:0] m_gout, m_goeb;
  bit          m_side;    // 0 = project owns, 1 = GPIO owns (valid when no guard)
  int          m_guard;   // guard cycles still to run, including the current one
  logic        m_ack;
  logic [31:0] m_dat;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] off);
    case (off)
      8'h00: return {31'b0, m_req};
      8'h04: return {30'b0, m_guard > 0, (m_guard == 0) && m_side};
      8'h08: return m_gout[31:0];
      8'h0C: return m_gout[63:32];
      8'h10: return m_goeb[31:0];
      8'h14: return m_goeb[63:32];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 1'b0; m_gout = '0; m_goeb = {32'h0, 32'hFFFF_FFFF} | {HI_MASK, 32'h0};
      m_side = 1'b0; m_guard = 0; m_ack = 1'b0; m_dat = '0;
    end else begin : step
      logic q;
      logic [7:0] off;
      q = stb && cyc && (adr[31:8] == BASE[31:8]) && !m_ack;
      off = adr[7:0];
      m_dat = (q && !we) ? mread(off) : 32'h0;
      if (m_guard > 0) begin
        m_guard--;
        if (m_guard == 0) m_side = ~m_side;
      end else if (m_req != m_side) begin
        m_guard = GUARD;
      end
      if (q && we) begin
        case (off)
          8'h00: if (sel[0]) m_req = dat_i[0];
          8'h08: m_gout[31:0]  = merge(m_gout[31:0], dat_i, sel);
          8'h0C: m_gout[63:32] = merge(m_gout[63:32], dat_i, sel) & HI_MASK;
          8'h10: m_goeb[31:0]  = merge(m_goeb[31:0], dat_i, sel);
          8'h14: m_goeb[63:32] = merge(m_goeb[63:32], dat_i, sel) & HI_MASK;
          default: ;
        endcase
      end
      m_ack = q;
    end
  end

  // Per-cycle compare against the model, plus event counters for directed checks
  always @(posedge clk) begin : compare
    logic [NPADS-1:0] e_out, e_oeb;
    #1;
    if (m_guard > 0) begin
      e_out = '0; e_oeb = '1;
    end else if (m_side) begin
      e_out = m_gout[NPADS-1:0]; e_oeb = m_goeb[NPADS-1:0];
    end else begin
      e_out = prj_out; e_oeb = prj_oeb;
    end
    chk("ack", {63'b0, ack}, {63'b0, m_ack});
    chk("dat_o", {32'b0, dat_o}, {32'b0, m_dat});
    chk("owner_o", {63'b0, owner}, {63'b0, (m_guard == 0) && m_side});
    chk("busy_o", {63'b0, busy}, {63'b0, m_guard > 0});
    chk("io_out", 64'(io_out), 64'(e_out));
    chk("io_oeb", 64'(io_oeb), 64'(e_oeb));
    if (busy) busy_cnt++;
    if (!busy && !owner) prj_cnt++;
    if (ack) ack_cnt++;
    if (ack && ack_prev) consec_cnt++;
    ack_prev = ack;
  end

  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | {24'h0, off}; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; rd = dat_o; end
    end
    chk("wb_ack_seen", {63'b0, got}, 64'd1);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    // Reset with the project driving all ones and enabling every pad
    prj_out = '1; prj_oeb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {63'b0, ack}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("prj_io_out", 64'(io_out), 64'h0000_003F_FFFF_FFFF);
    chk("prj_io_oeb", 64'(io_oeb), 64'h0);
    chk("prj_owner", {63'b0, owner}, 64'd0);
    wb_xfer(1'b0, 8'h04, 32'h0, 4'hF, rd);
    chk("status_rst", {32'b0, rd}, 64'h0);
    wb_xfer(1'b0, 8'h14, 32'h0, 4'hF, rd);
    chk("goeb_hi_rst", {32'b0, rd}, 64'h3F);

    // Hand over to GPIO: 4 guard cycles then the GPIO pattern reaches the pads
    wb_xfer(1'b1, 8'h08, 32'hA5A5_A5A5, 4'hF, rd);
    wb_xfer(1'b1, 8'h10, 32'h0, 4'hF, rd);
    busy_cnt = 0;
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd);
    repeat (8) @(negedge clk);
    chk("guard_len_to_wb", 64'(busy_cnt), 64'd4);
    chk("owner_wb", {63'b0, owner}, 64'd1);
    chk("gpio_out_lo", {32'b0, io_out[31:0]}, 64'hA5A5_A5A5);
    chk("gpio_oeb", 64'(io_oeb), 64'h0000_003F_0000_0000);

    // A->B->A: two full guards with one project cycle between them
    busy_cnt = 0; prj_cnt = 0;
    wb_xfer(1'b1, 8'h00, 32'h0, 4'hF, rd);
    wb_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd);
    repeat (12) @(negedge clk);
    chk("double_guard_busy", 64'(busy_cnt), 64'd8);
    chk("double_guard_prj", 64'(prj_cnt), 64'd1);
    chk("double_guard_owner", {63'b0, owner}, 64'd1);

    // Byte-lane write, unimplemented offset, HI register width
    wb_xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0010, rd);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd);
    chk("goeb_lane1", {32'b0, rd}, 64'h0000_FF00);
    wb_xfer(1'b0, 8'h40, 32'h0, 4'hF, rd);
    chk("unmapped_read", {32'b0, rd}, 64'h0);
    wb_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer(1'b0, 8'h0C, 32'h0, 4'hF, rd);
    chk("gout_hi_mask", {32'b0, rd}, 64'h3F);
    chk("gpio_out_hi", {58'b0, io_out[37:32]}, 64'h3F);

    // Strobe held three cycles: two accesses, never back-to-back acks
    ack_cnt = 0; consec_cnt = 0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h04; sel = 4'hF;
    repeat (3) @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_stb_acks", 64'(ack_cnt), 64'd2);
    chk("held_stb_consec", 64'(consec_cnt), 64'd0);

    // Reset on the 2nd guard cycle with an ack in flight
    wb_xfer(1'b1, 8'h00, 32'h0, 4'hF, rd);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h10; dat_i = 32'h0; sel = 4'hF;
    @(posedge clk); #2;
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    chk("pre_rst_ack", {63'b0, ack}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {63'b0, ack}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_owner", {63'b0, owner}, 64'd0);
    chk("mid_rst_io_out", 64'(io_out), 64'h0000_003F_FFFF_FFFF);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd);
    chk("ctrl_after_rst", {32'b0, rd}, 64'h0);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd);
    chk("goeb_after_rst", {32'b0, rd}, 64'hFFFF_FFFF);
    wb_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd);
    chk("gout_after_rst", {32'b0, rd}, 64'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
